data_mem_bank: RTL and testbench
================================

Name: data_mem_bank

Overview:
- Parametrised successor to the single-cycle word data memory in the MIPS pipeline MEM stage.
- Adds byte, halfword and word stores through byte lanes, and sign/zero-extended sub-word loads.
- Registered read with 1-cycle latency; misalignment detection.
- After reset, a hardware clear sequencer zeroes the array one word per cycle; this replaces the single-cycle bulk clear.

Parameters:
- ADDR_W, 10: word-address bits; DEPTH = 2**ADDR_W words.
- INIT_CLEAR, 1: 1 = run the clear sequence after reset; 0 = skip clear, go straight to RUN.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- addr  input  32  byte address; bits [ADDR_W+1:0] are used, upper bits ignored (aliasing).
- wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- mem_wr  input  1  store request.
- mem_rd  input  1  load request.
- size  input  2  00 = byte, 01 = half, 10 = word, 11 = reserved (treated as misaligned).
- sign_ext  input  1  1 = sign-extend sub-word load; 0 = zero-extend.
- pc  input  32  PC of the requesting instruction; used only by the trace feature.
- rdata  output  32  load result.
- rd_valid  output  1  one-cycle pulse; rdata is valid.
- addr_err  output  1  one-cycle pulse; misaligned or reserved-size request.
- busy  output  1  clear sequence in progress; requests are ignored.

Behaviour:
- State machine has two states, CLEAR and RUN.
- Asynchronous reset: state <= CLEAR (RUN if INIT_CLEAR=0), clr_idx <= 0, rdata <= 0, rd_valid <= 0, addr_err <= 0. busy = (state == CLEAR).
- CLEAR:
  - Each cycle, mem[clr_idx] <= 0 and clr_idx <= clr_idx+1.
  - When clr_idx == DEPTH-1, the word is written and state <= RUN next cycle.
  - Clear takes exactly DEPTH cycles after reset deassertion.
  - mem_rd and mem_wr are ignored: no write, no rd_valid, no addr_err.
- Reset mid-clear restarts the clear from index 0.
- RUN alignment check:
  - Byte requests are always aligned.
  - Half requests are misaligned if addr[0]=1.
  - Word requests are misaligned if addr[1:0]!=0.
  - size=11 is always an error.
- Misaligned (mem_rd|mem_wr): addr_err=1 next cycle, no array write, rd_valid=0, rdata unchanged.
- Store, word index = addr[ADDR_W+1:2]:
  - byte: lane addr[1:0] <= wdata[7:0].
  - half: lanes {addr[1],0} and {addr[1],1} <= wdata[15:0]; lower address = low byte (little-endian lanes).
  - word: all four lanes <= wdata.
  - Unselected lanes are unchanged.
- Load:
  - On the next rising edge, rdata <= extracted field, extended per sign_ext, and rd_valid <= 1 for one cycle.
  - Loads are back-to-back capable, one result per cycle.
- Same-cycle mem_rd and mem_wr to the same word: the load returns pre-write data (read-before-write); the store commits.
- Address aliasing: addresses beyond DEPTH*4 wrap modulo DEPTH*4.
- No request: rd_valid=0, addr_err=0, rdata holds its last value.

Optional Feature:
- Macro: DM_TRACE_EN.
- Defined: every committed store prints "@<pc hex>: *<word-aligned byte address hex, 32b> <= <full post-merge 32b word hex>" via $display at the commit edge. Misaligned stores and CLEAR-state writes are not printed.
- Undefined: no display statements; the pc port exists but is unused.

Test Plan:
- Assert reset, then release with ADDR_W=4 -> busy=1 for exactly 16 cycles; a load of word 5 afterwards returns 0x00000000 with rd_valid one cycle later.
- Store word 0x12345678 at 0x8, then load byte 0x9 with sign_ext=0 -> 0x00000056; load half 0xA with sign_ext=1 -> 0x00001234.
- Store byte 0x80 at 0xB over 0x12345678, then load byte 0xB with sign_ext=1 -> 0xFFFFFF80; load word 0x8 -> 0x80345678.
- Store half to 0x5 and load word from 0x6 -> addr_err pulses each time; memory is unchanged; rd_valid stays 0.
- Store word 0xAAAAAAAA at 0x0, then same cycle load word 0x0 and store 0x55555555 -> rdata=0xAAAAAAAA; a following load returns 0x55555555.
- Assert reset at clear cycle 7 while issuing mem_wr during CLEAR -> clear restarts, the store is dropped, and busy lasts DEPTH cycles after release.

Source files
------------

// File: rtl/data_mem_bank.sv
// Byte-lane data memory for the MEM stage: sized stores, extended loads, registered read and a post-reset clear sequencer.
// Optional store trace is compiled in with DM_TRACE_EN.
module data_mem_bank #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned INIT_CLEAR = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_wr,
    input  logic        mem_rd,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] pc,
    output logic [31:0] rdata,
    output logic        rd_valid,
    output logic        addr_err,
    output logic        busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam state_e RESET_STATE = (INIT_CLEAR != 0) ? ST_CLEAR : ST_RUN;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                rd_valid_q, rd_valid_d;
    logic                addr_err_q, addr_err_d;

    logic [31:0]         mem_q [DEPTH];

    logic [ADDR_W-1:0]   word_idx;
    logic [1:0]          lane;
    logic [31:0]         rd_word;
    logic                misalign;
    logic [3:0]          byte_en;
    logic [31:0]         lane_data;
    logic [7:0]          byte_sel;
    logic [15:0]         half_sel;
    logic [31:0]         load_val;

    logic                wr_en;
    logic [ADDR_W-1:0]   wr_idx;
    logic [31:0]         wr_word;
    logic                st_ok;
    logic                ld_ok;

    // Upper address bits alias by design; pc feeds only the optional trace.
    logic unused_bits;
    assign unused_bits = ^{addr[31:ADDR_W+2], pc};

    assign word_idx = addr[ADDR_W+1:2];
    assign lane     = addr[1:0];
    assign rd_word  = mem_q[word_idx];

    // Request decode: alignment, lane enables, replicated store data, load extraction.
    always_comb begin
        misalign  = 1'b0;
        byte_en   = 4'b0000;
        lane_data = wdata;
        case (size)
            2'b00: begin
                byte_en   = 4'(4'b0001 << lane);
                lane_data = {4{wdata[7:0]}};
            end
            2'b01: begin
                misalign  = lane[0];
                byte_en   = lane[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{wdata[15:0]}};
            end
            2'b10: begin
                misalign  = (lane != 2'b00);
                byte_en   = 4'b1111;
                lane_data = wdata;
            end
            default: begin
                misalign  = 1'b1;
                byte_en   = 4'b0000;
                lane_data = wdata;
            end
        endcase
    end

    always_comb begin
        byte_sel = 8'h00;
        case (lane)
            2'd0:    byte_sel = rd_word[7:0];
            2'd1:    byte_sel = rd_word[15:8];
            2'd2:    byte_sel = rd_word[23:16];
            default: byte_sel = rd_word[31:24];
        endcase
        half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];
        case (size)
            2'b00:   load_val = sign_ext ? {{24{byte_sel[7]}}, byte_sel}
                                         : {24'h000000, byte_sel};
            2'b01:   load_val = sign_ext ? {{16{half_sel[15]}}, half_sel}
                                         : {16'h0000, half_sel};
            default: load_val = rd_word;
        endcase
    end

    // State register and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RESET_STATE;
            clr_idx_q  <= '0;
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_idx_q  <= clr_idx_d;
            rdata_q    <= rdata_d;
            rd_valid_q <= rd_valid_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Next state: walk the clear index once, then stay in RUN until reset.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == ST_CLEAR) begin
            clr_idx_d = clr_idx_q + ADDR_W'(1);
            if (clr_idx_q == ADDR_W'(DEPTH - 1)) begin
                state_d = ST_RUN;
            end
        end
    end

    // Outputs and array write port; requests are dropped while clearing.
    always_comb begin
        st_ok      = 1'b0;
        ld_ok      = 1'b0;
        addr_err_d = 1'b0;
        wr_en      = 1'b0;
        wr_idx     = word_idx;
        wr_word    = '0;
        if (state_q == ST_CLEAR) begin
            wr_en  = 1'b1;
            wr_idx = clr_idx_q;
        end else begin
            addr_err_d = (mem_rd || mem_wr) && misalign;
            st_ok      = mem_wr && !misalign;
            ld_ok      = mem_rd && !misalign;
            wr_en      = st_ok;
            for (int i = 0; i < 4; i++) begin
                wr_word[8*i +: 8] = byte_en[i] ? lane_data[8*i +: 8] : rd_word[8*i +: 8];
            end
        end
        rd_valid_d = ld_ok;
        rdata_d    = ld_ok ? load_val : rdata_q;
    end

    // Array has no reset; contents are established by the clear sequencer.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_word;
        end
    end

`ifdef DM_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset && st_ok) begin
            $display("@%08h: *%08h <= %08h", pc, 32'({word_idx, 2'b00}), wr_word);
        end
    end
`else
`endif

    assign rdata    = rdata_q;
    assign rd_valid = rd_valid_q;
    assign addr_err = addr_err_q;
    assign busy     = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_data_mem_bank.sv
// Directed bench for data_mem_bank (ADDR_W=4): vector table plus clear / mid-clear reset sequences.
module tb_data_mem_bank;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_wr;
    logic        mem_rd;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] pc;
    logic [31:0] rdata;
    logic        rd_valid;
    logic        addr_err;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    data_mem_bank #(.ADDR_W(4), .INIT_CLEAR(1)) dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .wdata    (wdata),
        .mem_wr   (mem_wr),
        .mem_rd   (mem_rd),
        .size     (size),
        .sign_ext (sign_ext),
        .pc       (pc),
        .rdata    (rdata),
        .rd_valid (rd_valid),
        .addr_err (addr_err),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] wd;
        logic [1:0]  sz;
        logic        sx;
        logic        ev;
        logic        ee;
        logic [31:0] er;
    } vec_t;

    vec_t vecs [33];

    function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] a,
                                input logic [31:0] wd, input logic [1:0] sz, input logic sx,
                                input logic ev, input logic ee, input logic [31:0] er);
        vec_t v;
        v.rd = rd; v.wr = wr; v.a = a; v.wd = wd; v.sz = sz; v.sx = sx;
        v.ev = ev; v.ee = ee; v.er = er;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic idle();
        mem_rd = 1'b0; mem_wr = 1'b0; addr = '0; wdata = '0; size = 2'b10; sign_ext = 1'b0;
    endtask

    // Drive one request for one cycle, then compare outputs 1 ns after the edge.
    task automatic run_vec(input vec_t v, input string tag);
        mem_rd = v.rd; mem_wr = v.wr; addr = v.a; wdata = v.wd; size = v.sz; sign_ext = v.sx;
        pc = pc + 32'd4;
        @(posedge clk); #1;
        check({tag, " rd_valid"}, 32'(rd_valid), 32'(v.ev));
        check({tag, " addr_err"}, 32'(addr_err), 32'(v.ee));
        check({tag, " rdata"},    rdata,         v.er);
    endtask

    task automatic count_busy(output int cycles, output int bad);
        cycles = 0;
        bad    = 0;
        while (cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
            if (rd_valid || addr_err) bad++;
            if (!busy) break;
        end
    endtask

    initial begin
        int cyc;
        int bad;
        int bad_pre;

        vecs[0]  = mk(1, 0, 32'h14,       32'h0,        2'b10, 0, 1, 0, 32'h00000000);
        vecs[1]  = mk(0, 1, 32'h08,       32'h12345678, 2'b10, 0, 0, 0, 32'h00000000);
        vecs[2]  = mk(1, 0, 32'h09,       32'h0,        2'b00, 0, 1, 0, 32'h00000056);
        vecs[3]  = mk(1, 0, 32'h0A,       32'h0,        2'b01, 1, 1, 0, 32'h00001234);
        vecs[4]  = mk(0, 1, 32'h0B,       32'h00000080, 2'b00, 0, 0, 0, 32'h00001234);
        vecs[5]  = mk(1, 0, 32'h0B,       32'h0,        2'b00, 1, 1, 0, 32'hFFFFFF80);
        vecs[6]  = mk(1, 0, 32'h0B,       32'h0,        2'b00, 0, 1, 0, 32'h00000080);
        vecs[7]  = mk(1, 0, 32'h08,       32'h0,        2'b10, 0, 1, 0, 32'h80345678);
        vecs[8]  = mk(1, 0, 32'h08,       32'h0,        2'b00, 1, 1, 0, 32'h00000078);
        vecs[9]  = mk(1, 0, 32'h0A,       32'h0,        2'b01, 1, 1, 0, 32'hFFFF8034);
        vecs[10] = mk(1, 0, 32'h0A,       32'h0,        2'b01, 0, 1, 0, 32'h00008034);
        vecs[11] = mk(0, 1, 32'h05,       32'h0000BEEF, 2'b01, 0, 0, 1, 32'h00008034);
        vecs[12] = mk(1, 0, 32'h06,       32'h0,        2'b10, 0, 0, 1, 32'h00008034);
        vecs[13] = mk(1, 0, 32'h04,       32'h0,        2'b10, 0, 1, 0, 32'h00000000);
        vecs[14] = mk(1, 0, 32'h08,       32'h0,        2'b11, 0, 0, 1, 32'h00000000);
        vecs[15] = mk(0, 1, 32'h08,       32'hFFFFFFFF, 2'b11, 0, 0, 1, 32'h00000000);
        vecs[16] = mk(1, 0, 32'h08,       32'h0,        2'b10, 0, 1, 0, 32'h80345678);
        vecs[17] = mk(0, 1, 32'h06,       32'h0000BEEF, 2'b01, 0, 0, 0, 32'h80345678);
        vecs[18] = mk(1, 0, 32'h04,       32'h0,        2'b10, 0, 1, 0, 32'hBEEF0000);
        vecs[19] = mk(1, 0, 32'h06,       32'h0,        2'b01, 1, 1, 0, 32'hFFFFBEEF);
        vecs[20] = mk(0, 1, 32'h104,      32'h123456A5, 2'b00, 0, 0, 0, 32'hFFFFBEEF);
        vecs[21] = mk(1, 0, 32'h04,       32'h0,        2'b10, 0, 1, 0, 32'hBEEF00A5);
        vecs[22] = mk(1, 0, 32'hFFFFFFC8, 32'h0,        2'b10, 0, 1, 0, 32'h80345678);
        vecs[23] = mk(0, 1, 32'h00,       32'hAAAAAAAA, 2'b10, 0, 0, 0, 32'h80345678);
        vecs[24] = mk(1, 1, 32'h00,       32'h55555555, 2'b10, 0, 1, 0, 32'hAAAAAAAA);
        vecs[25] = mk(1, 0, 32'h00,       32'h0,        2'b10, 0, 1, 0, 32'h55555555);
        vecs[26] = mk(0, 0, 32'h00,       32'h0,        2'b10, 0, 0, 0, 32'h55555555);
        vecs[27] = mk(1, 1, 32'h02,       32'hFFFFFFFF, 2'b10, 0, 0, 1, 32'h55555555);
        vecs[28] = mk(1, 0, 32'h00,       32'h0,        2'b10, 0, 1, 0, 32'h55555555);
        vecs[29] = mk(0, 1, 32'h02,       32'h12345678, 2'b01, 0, 0, 0, 32'h55555555);
        vecs[30] = mk(1, 0, 32'h00,       32'h0,        2'b10, 0, 1, 0, 32'h56785555);
        vecs[31] = mk(0, 1, 32'h01,       32'h000000CC, 2'b00, 0, 0, 0, 32'h56785555);
        vecs[32] = mk(1, 0, 32'h00,       32'h0,        2'b10, 0, 1, 0, 32'h5678CC55);

        pc = 32'h00400000;
        idle();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset rdata",    rdata,          32'h0);
        check("reset rd_valid", 32'(rd_valid),  32'h0);
        check("reset addr_err", 32'(addr_err),  32'h0);
        check("reset busy",     32'(busy),      32'h1);

        reset = 1'b0;
        count_busy(cyc, bad);
        check("initial clear cycles", 32'(cyc), 32'd16);
        check("initial clear pulses", 32'(bad), 32'd0);

        for (int i = 0; i < 33; i++) begin
            run_vec(vecs[i], $sformatf("row%0d", i));
        end
        idle();
        @(posedge clk); #1;

        // Reset at clear cycle 7 with requests held active throughout.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        mem_rd = 1'b1; mem_wr = 1'b1; addr = 32'h0; wdata = 32'hFFFFFFFF; size = 2'b10;
        bad_pre = 0;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            check($sformatf("midclear busy c%0d", c), 32'(busy), 32'h1);
            if (rd_valid || addr_err) bad_pre++;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        check("midclear reset busy", 32'(busy), 32'h1);
        reset = 1'b0;
        count_busy(cyc, bad);
        idle();
        check("restart clear cycles", 32'(cyc), 32'd16);
        check("clear-state pulses", 32'(bad + bad_pre), 32'd0);

        run_vec(mk(1, 0, 32'h00, 32'h0, 2'b10, 0, 1, 0, 32'h00000000), "post-clear w0");
        run_vec(mk(1, 0, 32'h04, 32'h0, 2'b10, 0, 1, 0, 32'h00000000), "post-clear w1");
        run_vec(mk(1, 0, 32'h08, 32'h0, 2'b10, 0, 1, 0, 32'h00000000), "post-clear w2");
        idle();
        run_vec(mk(0, 0, 32'h00, 32'h0, 2'b10, 0, 0, 0, 32'h00000000), "post-clear idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
